// File: rtl/modem_demod_if.sv
// Sample-stream and decided-bit signals of the demodulator.
// The source side is master, the demodulator is slave.
interface modem_demod_if;
    logic [1:0] sel;
    logic [6:0] sample_in;
    logic       sample_valid;
    logic       bit_out;
    logic       bit_valid;
    logic       busy;

    modport master (
        output sel, sample_in, sample_valid,
        input  bit_out, bit_valid, busy
    );

    modport slave (
        input  sel, sample_in, sample_valid,
        output bit_out, bit_valid, busy
    );
endinterface

// File: rtl/modem_demod.sv
// ASK/FSK/BPSK/raw integrate-and-dump demodulator, one bit per SPS samples.
// Optional DEMOD_PREAMBLE_EN: hunt for 1010 before emitting data bits.
module modem_demod #(
    parameter int SPS    = 16,
    parameter int AMP_TH = 16,
    parameter int FSK_TH = 3
) (
    input logic          clk,
    input logic          rst,
    modem_demod_if.slave bus
);
    localparam int IW = $clog2(SPS);
    localparam int CW = IW + 1;
    localparam int AW = IW + 2;
    localparam logic [IW-1:0] LAST = IW'(SPS - 1);
    localparam logic [CW-1:0] HALF = CW'(SPS / 2);
    localparam logic [CW-1:0] FTH  = CW'(FSK_TH);
    localparam logic [6:0]    ATH  = 7'(AMP_TH);

    typedef enum logic [1:0] {
        M_ASK  = 2'b00,
        M_FSK  = 2'b01,
        M_BPSK = 2'b10,
        M_RAW  = 2'b11
    } mode_e;

    mode_e         mode_q, mode_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_nx;
    logic [AW-1:0] acc_q, acc_d, acc_nx;
    logic          prev_q, prev_d;
    logic          bit_q, bit_d;
    logic          vld_q, vld_d;
    logic          sgn, hit, chg;
    logic          dec, dec_bit, raw_v, emit;
    logic [6:0]    mag;

    assign sgn = bus.sample_in[6];
    assign mag = sgn ? bus.sample_in - 7'd64 : 7'd64 - bus.sample_in;
    assign chg = mode_e'(bus.sel) != mode_q;

    always_comb begin
        hit = 1'b0;
        case (mode_q)
            M_ASK:   hit = mag >= ATH;
            M_FSK:   hit = sgn != prev_q;
            default: hit = 1'b0;
        endcase
    end

    // BPSK reference is one carrier period: high for the first half-symbol
    assign cnt_nx = (&cnt_q) ? cnt_q : cnt_q + CW'(hit);
    assign acc_nx = (sgn == ~idx_q[IW-1]) ? acc_q + AW'(1)
                                          : acc_q - AW'(1);

    always_comb begin
        mode_d  = mode_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        prev_d  = prev_q;
        dec     = 1'b0;
        dec_bit = 1'b0;
        raw_v   = 1'b0;
        if (chg) begin
            mode_d = mode_e'(bus.sel);
            idx_d  = '0;
            cnt_d  = '0;
            acc_d  = '0;
        end else if (bus.sample_valid) begin
            prev_d = sgn;
            if (mode_q == M_RAW) begin
                raw_v = 1'b1;
            end else if (idx_q == LAST) begin
                idx_d = '0;
                cnt_d = '0;
                acc_d = '0;
                dec   = 1'b1;
                case (mode_q)
                    M_ASK:   dec_bit = cnt_nx >= HALF;
                    M_FSK:   dec_bit = cnt_nx >= FTH;
                    default: dec_bit = ~acc_nx[AW-1];
                endcase
            end else begin
                idx_d = idx_q + IW'(1);
                cnt_d = cnt_nx;
                acc_d = acc_nx;
            end
        end
    end

`ifdef DEMOD_PREAMBLE_EN
    typedef enum logic {S_HUNT, S_DATA} st_e;

    st_e        st_q, st_d;
    logic [3:0] hist_q, hist_d, hist_nx;

    assign hist_nx = {hist_q[2:0], dec_bit};

    always_comb begin
        st_d   = st_q;
        hist_d = hist_q;
        emit   = 1'b0;
        if (chg) begin
            st_d   = S_HUNT;
            hist_d = '0;
        end else if (dec) begin
            case (st_q)
                S_HUNT: begin
                    hist_d = hist_nx;
                    if (hist_nx == 4'b1010) st_d = S_DATA;
                end
                default: emit = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= S_HUNT;
            hist_q <= '0;
        end else begin
            st_q   <= st_d;
            hist_q <= hist_d;
        end
    end
`else
    assign emit = dec;
`endif

    always_comb begin
        bit_d = bit_q;
        vld_d = 1'b0;
        if (raw_v) begin
            bit_d = sgn;
            vld_d = 1'b1;
        end else if (emit) begin
            bit_d = dec_bit;
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= mode_e'(bus.sel);
            idx_q  <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
            prev_q <= 1'b1;
            bit_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            prev_q <= prev_d;
            bit_q  <= bit_d;
            vld_q  <= vld_d;
        end
    end

    assign bus.bit_out   = bit_q;
    assign bus.bit_valid = vld_q;
    assign bus.busy      = idx_q != '0;
endmodule

// File: tb/tb_modem_demod.sv
// Randomised and directed bench for modem_demod against a sample-list model.
// Model decides each symbol from the full list of its accepted samples.
module tb_modem_demod;
    localparam int SPS = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    modem_demod_if bus ();

    modem_demod #(.SPS(SPS), .AMP_TH(16), .FSK_TH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model state
    int   q[$];
    int   m_mode;
    bit   m_prev, start_prev;
    bit   e_bit, e_vld, e_busy;
    bit   chk_on = 0;
    bit   hunt;
    bit [3:0] hist;

    function automatic bit decide(input int mode);
        int n, a;
        bit p, s;
        n = 0;
        a = 0;
        p = start_prev;
        for (int i = 0; i < SPS; i++) begin
            s = q[i] >= 64;
            if (mode == 0 && (q[i] - 64 >= 16 || 64 - q[i] >= 16)) n++;
            if (mode == 1 && s != p) n++;
            p = s;
            a += (s == (i < SPS / 2)) ? 1 : -1;
        end
        if (mode == 0) return n >= SPS / 2;
        if (mode == 1) return n >= 3;
        return a >= 0;
    endfunction

    always @(posedge clk) begin
        bit b;
        e_vld = 0;
        if (rst) begin
            q.delete();
            m_mode = int'(bus.sel);
            m_prev = 1;
            e_bit  = 0;
            hunt   = 1;
            hist   = 0;
            chk_on = 1;
        end else if (int'(bus.sel) != m_mode) begin
            m_mode = int'(bus.sel);
            q.delete();
            hunt = 1;
            hist = 0;
        end else if (bus.sample_valid) begin
            if (m_mode == 3) begin
                e_bit = bus.sample_in >= 64;
                e_vld = 1;
            end else begin
                if (q.size() == 0) start_prev = m_prev;
                q.push_back(int'(bus.sample_in));
                if (q.size() == SPS) begin
                    b = decide(m_mode);
                    q.delete();
`ifdef DEMOD_PREAMBLE_EN
                    if (hunt) begin
                        hist = {hist[2:0], b};
                        if (hist == 4'b1010) hunt = 0;
                    end else begin
                        e_bit = b;
                        e_vld = 1;
                    end
`else
                    e_bit = b;
                    e_vld = 1;
`endif
                end
            end
            m_prev = bus.sample_in >= 64;
        end
        e_busy = q.size() != 0;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("bit_valid", int'(bus.bit_valid), int'(e_vld));
            chk("bit_out", int'(bus.bit_out), int'(e_bit));
            chk("busy", int'(bus.busy), int'(e_busy));
        end
    end

    task automatic drive(input logic r, input logic [1:0] s,
                         input logic v, input logic [6:0] x);
        @(negedge clk);
        rst = r;
        bus.sel = s;
        bus.sample_valid = v;
        bus.sample_in = x;
    endtask

    // n samples alternating between runs of a and b; optional idle gaps
    task automatic feed(input logic [1:0] s, input logic [6:0] a,
                        input logic [6:0] b, input int run,
                        input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            drive(0, s, 1, ((i / run) % 2 == 0) ? a : b);
            if (gap && i < n - 1) drive(0, s, 0, 7'd0);
        end
    endtask

    task automatic expect_pulse(input string nm, input int exp);
        @(posedge clk);
        #1;
        chk({nm, ".valid"}, int'(bus.bit_valid), 1);
        chk({nm, ".bit"}, int'(bus.bit_out), exp);
    endtask

    task automatic expect_none(input string nm);
        @(posedge clk);
        #1;
        chk({nm, ".novalid"}, int'(bus.bit_valid), 0);
    endtask

    initial begin
        logic [1:0] cs;
        logic [6:0] x;
        bus.sel = 2'b00;
        bus.sample_valid = 1'b0;
        bus.sample_in = 7'd64;
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("rst.bit_out", int'(bus.bit_out), 0);
        chk("rst.bit_valid", int'(bus.bit_valid), 0);
        chk("rst.busy", int'(bus.busy), 0);

`ifdef DEMOD_PREAMBLE_EN
        drive(0, 2, 0, 0);
        feed(2, 100, 28, 8, 16, 0); expect_none("pre1");
        feed(2, 28, 100, 8, 16, 0); expect_none("pre2");
        feed(2, 100, 28, 8, 16, 0); expect_none("pre3");
        feed(2, 28, 100, 8, 16, 0); expect_none("pre4");
        feed(2, 100, 28, 8, 16, 0); expect_pulse("pre5", 1);
        feed(2, 100, 28, 8, 16, 0); expect_pulse("pre6", 1);
`else
        feed(0, 100, 100, 16, 16, 0); expect_pulse("ask_strong", 1);
        feed(0, 64, 64, 16, 16, 0);   expect_pulse("ask_zero", 0);
        feed(0, 100, 64, 1, 16, 0);   expect_pulse("ask_tie", 1);
        drive(0, 1, 0, 0);
        feed(1, 80, 48, 4, 16, 0);    expect_pulse("fsk_many", 1);
        feed(1, 80, 48, 8, 16, 0);    expect_pulse("fsk_few", 0);
        drive(0, 2, 0, 0);
        feed(2, 100, 28, 8, 16, 0);   expect_pulse("bpsk_pos", 1);
        feed(2, 28, 100, 8, 16, 0);   expect_pulse("bpsk_neg", 0);
        feed(2, 100, 28, 4, 16, 0);   expect_pulse("bpsk_bal", 1);
        feed(2, 28, 100, 8, 16, 1);   expect_pulse("gap", 0);
        drive(0, 3, 0, 0);
        drive(0, 3, 1, 70);           expect_pulse("raw70", 1);
        drive(0, 3, 1, 10);           expect_pulse("raw10", 0);
        drive(0, 3, 0, 0);            expect_none("raw_end");
        drive(0, 0, 0, 0);
        feed(0, 100, 100, 16, 7, 0);
        drive(0, 1, 1, 80);           expect_none("chg");
        feed(1, 80, 80, 16, 15, 0);   expect_none("chg15");
        feed(1, 80, 80, 16, 1, 0);    expect_pulse("chg16", 0);
        drive(0, 0, 0, 0);
        feed(0, 100, 100, 16, 16, 0); expect_pulse("pre_rst", 1);
        feed(0, 100, 100, 16, 9, 0);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("midrst.busy", int'(bus.busy), 0);
        chk("midrst.valid", int'(bus.bit_valid), 0);
        chk("midrst.bit", int'(bus.bit_out), 0);
`endif

        cs = 2'b00;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 149) == 0) cs = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: x = 7'($urandom_range(0, 127));
                1: x = 7'($urandom_range(48, 80));
                2: x = 7'($urandom_range(90, 127));
                default: x = 7'($urandom_range(0, 38));
            endcase
            drive($urandom_range(0, 299) == 0, cs,
                  $urandom_range(0, 3) != 0, x);
        end
        drive(0, cs, 0, 0);
        drive(0, cs, 0, 0);
        drive(0, cs, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
